// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam int C_DEF_DATA_WIDTH = 8;
    localparam int C_EOP_BIT        = C_DEF_DATA_WIDTH;
    localparam int C_MAX_REQ        = 4;

    // Returns {hit, index}: first set bit of valid at or after ptr, wrapping modulo num_req.
    function automatic logic [2:0] rr_first(input logic [C_MAX_REQ-1:0] valid,
                                            input logic [1:0]           ptr,
                                            input int                   num_req);
        logic [2:0] res;
        int         idx;
        res = '0;
        // Walk from the farthest offset down so the nearest hit overwrites last.
        for (int k = C_MAX_REQ - 1; k >= 0; k--) begin
            if (k < num_req) begin
                idx = (int'(ptr) + k) % num_req;
                if (valid[idx]) res = {1'b1, 2'(idx)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first valid requester starting at rr_ptr.
module rr_priority_select
    import fifo_arb_pkg::*;
#(
    parameter  int G_NUM_REQ = 2,
    localparam int IW        = $clog2(G_NUM_REQ)
) (
    input  logic [G_NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]        rr_ptr,
    output logic                 hit,
    output logic [IW-1:0]        index
);

    logic [C_MAX_REQ-1:0] valid_ext;
    logic [2:0]           res;

    always_comb begin
        valid_ext                = '0;
        valid_ext[G_NUM_REQ-1:0] = req_valid;
        res                      = rr_first(valid_ext, 2'(rr_ptr), G_NUM_REQ);
        hit                      = res[2];
        index                    = res[IW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port between requesters,
// throttled by the FIFO fill level with the in-flight write counted as used.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int G_DATA_WIDTH_BITS = 8,
    parameter  int G_ADDR_WIDTH_BITS = 6,
    parameter  int G_NUM_REQ         = 2,
    localparam int IW                = $clog2(G_NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [G_NUM_REQ-1:0]                   req_valid,
    input  logic [G_NUM_REQ*G_DATA_WIDTH_BITS-1:0] req_data,
    input  logic [G_NUM_REQ-1:0]                   req_eop,
    output logic [G_NUM_REQ-1:0]                   req_ready,
    output logic                                   fifo_w_en,
    output logic [G_DATA_WIDTH_BITS:0]             fifo_w_data,
    input  logic [G_ADDR_WIDTH_BITS:0]             fifo_fill_level,
    output logic                                   busy,
    output logic [IW-1:0]                          owner
);

    localparam int W     = G_DATA_WIDTH_BITS;
    localparam int SW    = G_ADDR_WIDTH_BITS + 2;
    localparam int DEPTH = 2 ** G_ADDR_WIDTH_BITS;

    arb_state_t    state;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] rr_ptr;
    logic          hit;
    logic [IW-1:0] sel_idx;
    logic [SW-1:0] used;
    logic [SW-1:0] space;
    logic          xfer;
    logic [W-1:0]  owner_data;
    logic          owner_eop;
    logic [IW-1:0] next_ptr;

    rr_priority_select #(.G_NUM_REQ(G_NUM_REQ)) u_sel (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .hit       (hit),
        .index     (sel_idx)
    );

    // An over-full or in-flight-saturated FIFO clamps to zero space.
    always_comb begin
        used  = SW'(fifo_fill_level) + SW'(fifo_w_en);
        space = (used > SW'(DEPTH)) ? '0 : SW'(DEPTH) - used;
    end

    for (genvar i = 0; i < G_NUM_REQ; i++) begin : g_ready
        assign req_ready[i] = (state == ARB_LOCKED) && (owner_q == IW'(i)) && (space != '0);
    end

    assign xfer       = req_valid[owner_q] && req_ready[owner_q];
    assign owner_data = req_data[owner_q*W +: W];
    assign owner_eop  = req_eop[owner_q];
    assign next_ptr   = (owner_q == IW'(G_NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr      <= '0;
            fifo_w_en   <= 1'b0;
            fifo_w_data <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    fifo_w_en <= 1'b0;
                    if (hit) begin
                        owner_q <= sel_idx;
                        state   <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    fifo_w_en <= xfer;
                    if (xfer) begin
                        fifo_w_data <= {owner_eop, owner_data};
                        if (owner_eop) begin
                            state  <= ARB_IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign busy  = (state == ARB_LOCKED);
    assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: two requesters, 64-deep FIFO modelled by a counter.
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v1, e0, e1;
    logic [7:0] d0, d1;
    logic [1:0] req_valid, req_eop, req_ready;
    logic [15:0] req_data;
    logic       fifo_w_en;
    logic [8:0] fifo_w_data;
    logic [6:0] cnt;
    logic       busy;
    logic       owner;
    logic       rd_en, preload;
    logic [6:0] preload_val;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         max_cnt = 0;
    logic [8:0] wr_q[$];
    int         wr_t[$];
    bit         drv_done;

    assign req_valid = {v1, v0};
    assign req_eop   = {e1, e0};
    assign req_data  = {d1, d0};

    fifo_wr_arbiter #(.G_DATA_WIDTH_BITS(8), .G_ADDR_WIDTH_BITS(6), .G_NUM_REQ(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_eop         (req_eop),
        .req_ready       (req_ready),
        .fifo_w_en       (fifo_w_en),
        .fifo_w_data     (fifo_w_data),
        .fifo_fill_level (cnt),
        .busy            (busy),
        .owner           (owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO occupancy model: fill level updates one edge after the write strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (preload) cnt <= preload_val;
        else              cnt <= cnt + 7'(fifo_w_en) - 7'(rd_en && cnt != 0);
    end

    always @(negedge clk) begin
        if (rst_n && fifo_w_en) begin
            wr_q.push_back(fifo_w_data);
            wr_t.push_back(cyc);
        end
        if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic set_lane(input int lane, input logic v, input logic [7:0] d, input logic e);
        if (lane == 0) begin v0 = v; d0 = d; e0 = e; end
        else           begin v1 = v; d1 = d; e1 = e; end
    endtask

    task automatic wait_ready(input int lane, output bit ok);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready[lane]) begin ok = 1; return; end
        end
        ok = 0;
        n_cmp++; n_fail++;
        $display("FAIL wait_ready lane %0d: ready stayed 0 for 100 cycles, required 1", lane);
    endtask

    task automatic send_pkt(input int lane, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int len);
        logic [7:0] b[3];
        bit ok;
        b = '{b0, b1, b2};
        for (int i = 0; i < len; i++) begin
            set_lane(lane, 1'b1, b[i], i == len - 1);
            wait_ready(lane, ok);
            if (!ok) break;
            tick();
        end
        set_lane(lane, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset;
        tick();
        rst_n = 1'b0;
        v0 = 0; v1 = 0; e0 = 0; e1 = 0;
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, req_ready, fifo_w_en, fifo_w_data, owner} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b ready=%b w_en=%b w_data=%h owner=%b, required all 0",
                     busy, req_ready, fifo_w_en, fifo_w_data, owner);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({req_ready, fifo_w_en, busy} !== 4'b0) begin
                n_fail++;
                $display("FAIL idle_quiet cyc %0d: ready=%b w_en=%b busy=%b, required 0", i,
                         req_ready, fifo_w_en, busy);
            end
        end
    endtask

    task automatic test_single_packet;
        int base, c0;
        logic [8:0] exp[3];
        exp  = '{9'h011, 9'h022, 9'h133};
        base = wr_q.size();
        tick();
        c0 = cyc;
        send_pkt(0, 8'h11, 8'h22, 8'h33, 3);
        repeat (3) tick();
        n_cmp++;
        if (wr_q.size() != base + 3) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes, required 3", wr_q.size() - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (wr_q[base+k] !== exp[k] || wr_t[base+k] != c0 + 2 + k) begin
                    n_fail++;
                    $display("FAIL single_write %0d: data=%h at cyc %0d, required %h at cyc %0d",
                             k, wr_q[base+k], wr_t[base+k], exp[k], c0 + 2 + k);
                end
            end
        end
    endtask

    task automatic test_round_robin;
        int base;
        logic [8:0] exp[8];
        int off[8];
        exp = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1};
        off = '{0, 1, 3, 4, 6, 7, 9, 10};
        do_reset();
        base = wr_q.size();
        fork
            begin send_pkt(0, 8'hA0, 8'hA1, 8'h00, 2); send_pkt(0, 8'hA0, 8'hA1, 8'h00, 2); end
            begin send_pkt(1, 8'hB0, 8'hB1, 8'h00, 2); send_pkt(1, 8'hB0, 8'hB1, 8'h00, 2); end
        join
        repeat (2) tick();
        n_cmp++;
        if (wr_q.size() != base + 8) begin
            n_fail++;
            $display("FAIL rr_count: got %0d writes, required 8", wr_q.size() - base);
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (wr_q[base+k] !== exp[k] || wr_t[base+k] - wr_t[base] != off[k]) begin
                    n_fail++;
                    $display("FAIL rr_write %0d: data=%h offset %0d, required %h offset %0d", k,
                             wr_q[base+k], wr_t[base+k] - wr_t[base], exp[k], off[k]);
                end
            end
        end
    endtask

    task automatic test_fifo_full;
        int base;
        base = wr_q.size();
        preload_val = 7'd63; preload = 1'b1;
        tick();
        preload = 1'b0;
        drv_done = 0;
        fork
            begin send_pkt(0, 8'hC1, 8'hC2, 8'hC3, 3); drv_done = 1; end
        join_none
        repeat (12) tick();
        @(negedge clk);
        n_cmp++;
        if (wr_q.size() != base + 1 || cnt !== 7'd64 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL full_stall: writes=%0d fill=%0d ready=%b, required 1 64 00",
                     wr_q.size() - base, cnt, req_ready);
        end
        tick();
        rd_en = 1'b1;
        repeat (4) tick();
        rd_en = 1'b0;
        for (int k = 0; k < 200 && !drv_done; k++) tick();
        repeat (2) tick();
        n_cmp++;
        if (wr_q.size() != base + 3 || wr_q[wr_q.size()-1] !== 9'h1C3) begin
            n_fail++;
            $display("FAIL full_resume: writes=%0d last=%h, required 3 1c3",
                     wr_q.size() - base, wr_q[wr_q.size()-1]);
        end
        n_cmp++;
        if (max_cnt > 64) begin
            n_fail++;
            $display("FAIL full_overflow: max fill %0d, required <= 64", max_cnt);
        end
        preload_val = 7'd0; preload = 1'b1;
        tick();
        preload = 1'b0;
    endtask

    task automatic test_owner_hold;
        int base;
        bit ok;
        base = wr_q.size();
        set_lane(0, 1'b1, 8'h51, 1'b0);
        wait_ready(0, ok);
        tick();
        set_lane(0, 1'b0, 8'h00, 1'b0);
        set_lane(1, 1'b1, 8'h61, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({owner, busy, req_ready[1]} !== 3'b010) begin
                n_fail++;
                $display("FAIL hold_lock cyc %0d: owner=%b busy=%b ready1=%b, required 0 1 0",
                         i, owner, busy, req_ready[1]);
            end
            tick();
        end
        set_lane(0, 1'b1, 8'h52, 1'b1);
        wait_ready(0, ok);
        tick();
        set_lane(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({busy, req_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_idle: busy=%b ready=%b, required 0 00", busy, req_ready);
        end
        wait_ready(1, ok);
        n_cmp++;
        if ({owner, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_handover: owner=%b busy=%b, required 1 1", owner, busy);
        end
        tick();
        set_lane(1, 1'b0, 8'h00, 1'b0);
        repeat (2) tick();
        n_cmp++;
        if (wr_q.size() != base + 3 || wr_q[base] !== 9'h051 || wr_q[base+1] !== 9'h152 ||
            wr_q[base+2] !== 9'h161) begin
            n_fail++;
            $display("FAIL hold_writes: count=%0d, required 3 writes 051 152 161", wr_q.size() - base);
        end
    endtask

    task automatic test_reset_mid_packet;
        int base;
        bit ok;
        base = wr_q.size();
        send_pkt(0, 8'h71, 8'h00, 8'h00, 1);
        repeat (2) tick();
        n_cmp++;
        if (wr_q.size() != base + 1 || wr_q[base] !== 9'h171) begin
            n_fail++;
            $display("FAIL single_char: writes=%0d, required 1 write of 171", wr_q.size() - base);
        end
        set_lane(1, 1'b1, 8'h81, 1'b0);
        wait_ready(1, ok);
        tick();
        set_lane(1, 1'b1, 8'h82, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, req_ready, fifo_w_en, fifo_w_data, owner} !== 14'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b ready=%b w_en=%b w_data=%h owner=%b, required all 0",
                     busy, req_ready, fifo_w_en, fifo_w_data, owner);
        end
        @(negedge clk) rst_n = 1'b1;
        set_lane(0, 1'b1, 8'h91, 1'b1);
        tick();
        @(negedge clk);
        n_cmp++;
        if ({owner, busy, req_ready} !== 4'b0101) begin
            n_fail++;
            $display("FAIL reset_rr_ptr: owner=%b busy=%b ready=%b, required 0 1 01",
                     owner, busy, req_ready);
        end
        tick();
        set_lane(0, 1'b0, 8'h00, 1'b0);
        set_lane(1, 1'b0, 8'h00, 1'b0);
        repeat (2) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 0; v1 = 0; e0 = 0; e1 = 0; d0 = '0; d1 = '0;
        rd_en = 0; preload = 0; preload_val = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_fifo_full();
        test_owner_hold();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
